aes_uart_baudgen: RTL and testbench

Baud-rate generator for the AES-UART core. It consumes the BRR register (12-bit mantissa, 4-bit fraction) and CR1.aue from the AXI-Lite register block. It produces the 16x oversampling tick, the transmitter bit tick, and a realignable receiver mid-bit sample tick. It sits between the register file and the UART TX/RX shifters.

---
 rtl/axilregs_pkg.sv | 28 ++
 rtl/uart_frac_div.sv | 123 ++++++++++++
 rtl/aes_uart_baudgen.sv | 94 +++++++++
 tb/tb_aes_uart_baudgen.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axilregs_pkg.sv
// Register-block types shared by the AES-UART core: BRR layout and baud-generator constants.
// The fractional divider is enabled by defining AES_UART_BAUD_FRAC_EN.
package axilregs_pkg;

  localparam int MANT_W       = 12;
  localparam int FRAC_W       = 4;
  localparam int PHASE_W      = 4;
  localparam int OS_RATE      = 16;
  localparam int RX_MID_PHASE = 7;

  typedef struct packed {
    logic [15:0]       rsvd;
    logic [MANT_W-1:0] mantissa;
    logic [FRAC_W-1:0] fraction;
  } brr_reg_t;

  // Advance an oversample phase, wrapping after OS_RATE-1.
  function automatic logic [PHASE_W-1:0] phase_inc(input logic [PHASE_W-1:0] ph);
    logic [PHASE_W-1:0] nxt;
    if (ph == PHASE_W'(OS_RATE - 1)) begin
      nxt = {PHASE_W{1'b0}};
    end else begin
      nxt = ph + {{(PHASE_W-1){1'b0}}, 1'b1};
    end
    return nxt;
  endfunction

endpackage

// File: rtl/uart_frac_div.sv
// Fractional baud divider: BRR shadow register, down-counter, fraction accumulator and os_tick.
// Accumulator exists only when AES_UART_BAUD_FRAC_EN is defined; otherwise periods are exactly mantissa.
module uart_frac_div
  import axilregs_pkg::*;
#(
  parameter int CNT_W = MANT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MANT_W-1:0] brr_mant,
  input  logic [FRAC_W-1:0] brr_frac,
  input  logic              brr_wr,
  output logic              tick,
  output logic              restart,
  output logic              os_tick,
  output logic              cfg_err
);

  localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             en_d_r;
  logic [CNT_W-1:0] mant_r;
  logic [CNT_W-1:0] mant_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             latch_s;
  logic             active_s;
  logic             tick_s;
  logic             carry_s;
  logic             cfg_err_nxt_s;
  logic             os_tick_r;
  logic             cfg_err_r;

  // A BRR write or an enable rising edge both reload the shadow and restart the divider.
  assign latch_s    = brr_wr | (en & ~en_d_r);
  assign mant_nxt_s = latch_s ? CNT_W'(brr_mant) : mant_r;
  assign active_s   = en & (mant_r != ZERO_C);
  assign tick_s     = active_s & (cnt_r == ZERO_C) & ~latch_s;

`ifdef AES_UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] frac_r;
  logic [FRAC_W-1:0] frac_nxt_s;
  logic [FRAC_W-1:0] acc_r;
  logic [FRAC_W-1:0] acc_nxt_s;
  logic [FRAC_W:0]   sum_s;

  // Fraction shadow and accumulator; the carry stretches one period by a clock.
  always_comb begin
    sum_s      = {1'b0, acc_r} + {1'b0, frac_r};
    carry_s    = 1'b0;
    frac_nxt_s = frac_r;
    acc_nxt_s  = acc_r;
    if (latch_s) begin
      frac_nxt_s = brr_frac;
      acc_nxt_s  = {FRAC_W{1'b0}};
    end else if (!en) begin
      acc_nxt_s  = {FRAC_W{1'b0}};
    end else if (tick_s) begin
      carry_s    = sum_s[FRAC_W];
      acc_nxt_s  = sum_s[FRAC_W-1:0];
    end else begin
      acc_nxt_s  = acc_r;
    end
  end

  // Fraction state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frac_r <= {FRAC_W{1'b0}};
      acc_r  <= {FRAC_W{1'b0}};
    end else begin
      frac_r <= frac_nxt_s;
      acc_r  <= acc_nxt_s;
    end
  end
`else
  logic [FRAC_W-1:0] frac_unused_s;
  assign frac_unused_s = brr_frac;
  assign carry_s       = 1'b0;
`endif

  // Counter next state: restart and disabled both park it at mantissa-1.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (latch_s) begin
      cnt_nxt_s = mant_nxt_s - ONE_C;
    end else if (!en) begin
      cnt_nxt_s = mant_r - ONE_C;
    end else if (tick_s) begin
      cnt_nxt_s = mant_r - ONE_C + {{(CNT_W-1){1'b0}}, carry_s};
    end else if (active_s) begin
      cnt_nxt_s = cnt_r - ONE_C;
    end else begin
      cnt_nxt_s = cnt_r;
    end
    cfg_err_nxt_s = en & (mant_nxt_s == ZERO_C);
  end

  // Divider state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_d_r    <= 1'b0;
      mant_r    <= ZERO_C;
      cnt_r     <= ZERO_C;
      os_tick_r <= 1'b0;
      cfg_err_r <= 1'b0;
    end else begin
      en_d_r    <= en;
      mant_r    <= mant_nxt_s;
      cnt_r     <= cnt_nxt_s;
      os_tick_r <= tick_s;
      cfg_err_r <= cfg_err_nxt_s;
    end
  end

  assign tick    = tick_s;
  assign restart = latch_s;
  assign os_tick = os_tick_r;
  assign cfg_err = cfg_err_r;

endmodule

// File: rtl/aes_uart_baudgen.sv
// AES-UART baud generator top: fractional divider plus TX/RX oversample phase counters and tick decode.
// Optional fractional divide is built when AES_UART_BAUD_FRAC_EN is defined.
module aes_uart_baudgen
  import axilregs_pkg::*;
#(
  parameter int CNT_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  brr_reg_t           brr,
  input  logic               brr_wr,
  input  logic               rx_sync,
  output logic               os_tick,
  output logic               tx_bit_tick,
  output logic               rx_sample_tick,
  output logic [PHASE_W-1:0] rx_os_phase,
  output logic               cfg_err
);

  logic               tick_s;
  logic               restart_s;
  logic [PHASE_W-1:0] tx_phase_r;
  logic [PHASE_W-1:0] tx_phase_nxt_s;
  logic [PHASE_W-1:0] rx_phase_r;
  logic [PHASE_W-1:0] rx_phase_nxt_s;
  logic               tx_bit_tick_nxt_s;
  logic               rx_sample_tick_nxt_s;
  logic               tx_bit_tick_r;
  logic               rx_sample_tick_r;
  logic [15:0]        rsvd_unused_s;

  assign rsvd_unused_s = brr.rsvd;

  uart_frac_div #(
    .CNT_W (CNT_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .brr_mant (brr.mantissa),
    .brr_frac (brr.fraction),
    .brr_wr   (brr_wr),
    .tick     (tick_s),
    .restart  (restart_s),
    .os_tick  (os_tick),
    .cfg_err  (cfg_err)
  );

  // Phase counters; rx_sync realigns only the RX phase and wins over a coincident tick.
  always_comb begin
    tx_phase_nxt_s = tx_phase_r;
    rx_phase_nxt_s = rx_phase_r;
    if (restart_s || !en) begin
      tx_phase_nxt_s = {PHASE_W{1'b0}};
      rx_phase_nxt_s = {PHASE_W{1'b0}};
    end else begin
      if (tick_s) begin
        tx_phase_nxt_s = phase_inc(tx_phase_r);
      end else begin
        tx_phase_nxt_s = tx_phase_r;
      end
      if (rx_sync) begin
        rx_phase_nxt_s = {PHASE_W{1'b0}};
      end else if (tick_s) begin
        rx_phase_nxt_s = phase_inc(rx_phase_r);
      end else begin
        rx_phase_nxt_s = rx_phase_r;
      end
    end
    tx_bit_tick_nxt_s    = tick_s & (tx_phase_r == PHASE_W'(OS_RATE - 1));
    rx_sample_tick_nxt_s = tick_s & ~rx_sync & (rx_phase_r == PHASE_W'(RX_MID_PHASE));
  end

  // Phase registers and decoded tick outputs, aligned with os_tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_phase_r       <= {PHASE_W{1'b0}};
      rx_phase_r       <= {PHASE_W{1'b0}};
      tx_bit_tick_r    <= 1'b0;
      rx_sample_tick_r <= 1'b0;
    end else begin
      tx_phase_r       <= tx_phase_nxt_s;
      rx_phase_r       <= rx_phase_nxt_s;
      tx_bit_tick_r    <= tx_bit_tick_nxt_s;
      rx_sample_tick_r <= rx_sample_tick_nxt_s;
    end
  end

  assign tx_bit_tick    = tx_bit_tick_r;
  assign rx_sample_tick = rx_sample_tick_r;
  assign rx_os_phase    = rx_phase_r;

endmodule

// File: tb/tb_aes_uart_baudgen.sv
// Directed self-checking bench for aes_uart_baudgen; expectations follow AES_UART_BAUD_FRAC_EN.
module tb_aes_uart_baudgen;
  import axilregs_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       brr_wr;
  logic       rx_sync;
  brr_reg_t   brr;
  logic       os_tick;
  logic       tx_bit_tick;
  logic       rx_sample_tick;
  logic [3:0] rx_os_phase;
  logic       cfg_err;

  int errors = 0;
  int checks = 0;

`ifdef AES_UART_BAUD_FRAC_EN
  localparam int SPAN16 = 72;
  localparam int GAP23  = 5;
`else
  localparam int SPAN16 = 64;
  localparam int GAP23  = 4;
`endif

  always #5 clk = ~clk;

  aes_uart_baudgen dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .brr            (brr),
    .brr_wr         (brr_wr),
    .rx_sync        (rx_sync),
    .os_tick        (os_tick),
    .tx_bit_tick    (tx_bit_tick),
    .rx_sample_tick (rx_sample_tick),
    .rx_os_phase    (rx_os_phase),
    .cfg_err        (cfg_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_brr(input int m, input int f);
    brr          = '0;
    brr.mantissa = 12'(m);
    brr.fraction = 4'(f);
  endtask

  task automatic write_brr(input int m, input int f);
    set_brr(m, f);
    brr_wr = 1'b1;
    step();
    brr_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; brr_wr = 1'b0; rx_sync = 1'b0; brr = '0;
    step(); step();
    checks++;
    if ({os_tick, tx_bit_tick, rx_sample_tick, cfg_err, rx_os_phase} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=00", {os_tick, tx_bit_tick, rx_sample_tick, cfg_err, rx_os_phase});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_m4();
    logic e;
    set_brr(4, 0);
    en = 1'b1;
    step();
    for (int k = 1; k <= 130; k++) begin
      step();
      e = ((k % 4) == 0);
      checks++;
      if (os_tick !== e) begin errors++; $display("FAIL m4_os_tick k=%0d got=%b exp=%b", k, os_tick, e); end
      e = ((k % 64) == 0);
      checks++;
      if (tx_bit_tick !== e) begin errors++; $display("FAIL m4_tx_bit_tick k=%0d got=%b exp=%b", k, tx_bit_tick, e); end
      e = ((k % 64) == 32);
      checks++;
      if (rx_sample_tick !== e) begin errors++; $display("FAIL m4_rx_sample k=%0d got=%b exp=%b", k, rx_sample_tick, e); end
      checks++;
      if (cfg_err !== 1'b0) begin errors++; $display("FAIL m4_cfg_err k=%0d got=%b exp=0", k, cfg_err); end
    end
  endtask

  task automatic test_frac();
    int t[17];
    int n = 0;
    for (int i = 0; i < 17; i++) t[i] = 0;
    write_brr(4, 8);
    for (int k = 1; k <= 120; k++) begin
      step();
      if (os_tick && n < 17) begin t[n] = k; n++; end
    end
    checks++;
    if (t[0] !== 4) begin errors++; $display("FAIL frac_first got=%0d exp=4", t[0]); end
    checks++;
    if (t[2] - t[1] !== GAP23) begin errors++; $display("FAIL frac_gap23 got=%0d exp=%0d", t[2] - t[1], GAP23); end
    checks++;
    if (t[16] - t[0] !== SPAN16) begin errors++; $display("FAIL frac_span16 got=%0d exp=%0d", t[16] - t[0], SPAN16); end
  endtask

  task automatic test_m1();
    logic e;
    write_brr(1, 0);
    for (int k = 1; k <= 48; k++) begin
      step();
      checks++;
      if (os_tick !== 1'b1) begin errors++; $display("FAIL m1_os_tick k=%0d got=%b exp=1", k, os_tick); end
      e = ((k % 16) == 0);
      checks++;
      if (tx_bit_tick !== e) begin errors++; $display("FAIL m1_tx_bit_tick k=%0d got=%b exp=%b", k, tx_bit_tick, e); end
      e = ((k % 16) == 8);
      checks++;
      if (rx_sample_tick !== e) begin errors++; $display("FAIL m1_rx_sample k=%0d got=%b exp=%b", k, rx_sample_tick, e); end
      checks++;
      if (rx_os_phase !== 4'(k % 16)) begin errors++; $display("FAIL m1_phase k=%0d got=%0d exp=%0d", k, rx_os_phase, k % 16); end
    end
  endtask

  // Waits for an os_tick, issues rx_sync one cycle later, then expects the sample on the 8th tick.
  task automatic test_rx_sync();
    int n = 0;
    int early = 0;
    bit found = 1'b0;
    write_brr(4, 0);
    for (int k = 0; k < 10 && !found; k++) begin
      step();
      if (os_tick) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rxs_wait_tick got=none exp=tick"); end
    rx_sync = 1'b1;
    step();
    rx_sync = 1'b0;
    checks++;
    if (rx_os_phase !== 4'd0) begin errors++; $display("FAIL rxs_phase0 got=%0d exp=0", rx_os_phase); end
    for (int k = 0; k < 40 && n < 8; k++) begin
      step();
      if (os_tick) n++;
      if (rx_sample_tick && n < 8) early++;
    end
    checks++;
    if (n !== 8) begin errors++; $display("FAIL rxs_tick_count got=%0d exp=8", n); end
    checks++;
    if (rx_sample_tick !== 1'b1) begin errors++; $display("FAIL rxs_sample8 got=%b exp=1", rx_sample_tick); end
    checks++;
    if (early !== 0) begin errors++; $display("FAIL rxs_early got=%0d exp=0", early); end
  endtask

  // rx_sync lands in the very cycle the phase-7 tick would produce a sample.
  task automatic test_rx_sync_coincident();
    int n = 0;
    bit found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      step();
      if (os_tick) found = 1'b1;
    end
    rx_sync = 1'b1;
    step();
    rx_sync = 1'b0;
    for (int k = 0; k < 40 && n < 7; k++) begin
      step();
      if (os_tick) n++;
    end
    step(); step(); step();
    checks++;
    if (rx_os_phase !== 4'd7) begin errors++; $display("FAIL rxc_pre_phase got=%0d exp=7", rx_os_phase); end
    rx_sync = 1'b1;
    step();
    rx_sync = 1'b0;
    checks++;
    if (os_tick !== 1'b1) begin errors++; $display("FAIL rxc_os_tick got=%b exp=1", os_tick); end
    checks++;
    if (rx_sample_tick !== 1'b0) begin errors++; $display("FAIL rxc_suppressed got=%b exp=0", rx_sample_tick); end
    checks++;
    if (rx_os_phase !== 4'd0) begin errors++; $display("FAIL rxc_phase got=%0d exp=0", rx_os_phase); end
    n = 0;
    for (int k = 0; k < 40 && n < 8; k++) begin
      step();
      if (os_tick) n++;
    end
    checks++;
    if (rx_sample_tick !== 1'b1 || n !== 8) begin
      errors++; $display("FAIL rxc_realign got=%b/%0d exp=1/8", rx_sample_tick, n);
    end
  endtask

  task automatic test_cfg_err();
    int ticks = 0;
    int err_low = 0;
    logic e;
    write_brr(0, 0);
    checks++;
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_set got=%b exp=1", cfg_err); end
    for (int k = 0; k < 12; k++) begin
      step();
      if (os_tick || tx_bit_tick || rx_sample_tick) ticks++;
      if (!cfg_err) err_low++;
    end
    checks++;
    if (ticks !== 0) begin errors++; $display("FAIL cfg_no_ticks got=%0d exp=0", ticks); end
    checks++;
    if (err_low !== 0) begin errors++; $display("FAIL cfg_hold got=%0d exp=0", err_low); end
    checks++;
    if (rx_os_phase !== 4'd0) begin errors++; $display("FAIL cfg_phase got=%0d exp=0", rx_os_phase); end
    write_brr(6, 0);
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_clear got=%b exp=0", cfg_err); end
    for (int k = 1; k <= 6; k++) begin
      step();
      e = (k == 6);
      checks++;
      if (os_tick !== e) begin errors++; $display("FAIL cfg_m6_first k=%0d got=%b exp=%b", k, os_tick, e); end
    end
  endtask

  task automatic test_en_low();
    int bad = 0;
    logic e;
    write_brr(4, 0);
    for (int k = 0; k < 6; k++) step();
    en = 1'b0;
    step();
    for (int k = 0; k < 10; k++) begin
      if ({os_tick, tx_bit_tick, rx_sample_tick, cfg_err, rx_os_phase} !== 8'h00) bad++;
      step();
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL enlow_quiet got=%0d exp=0", bad); end
    write_brr(0, 0);
    step();
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL enlow_cfg_err got=%b exp=0", cfg_err); end
    set_brr(4, 0);
    en = 1'b1;
    step();
    for (int k = 1; k <= 8; k++) begin
      step();
      e = ((k % 4) == 0);
      checks++;
      if (os_tick !== e) begin errors++; $display("FAIL enrise_os_tick k=%0d got=%b exp=%b", k, os_tick, e); end
    end
  endtask

  task automatic test_rst_mid();
    int bad = 0;
    bit found = 1'b0;
    logic e;
    for (int k = 0; k < 10 && !found; k++) begin
      step();
      if (os_tick) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rst_wait_tick got=none exp=tick"); end
    rst = 1'b1;
    #1;
    checks++;
    if ({os_tick, tx_bit_tick, rx_sample_tick, cfg_err, rx_os_phase} !== 8'h00) begin
      errors++;
      $display("FAIL rst_immediate got=%h exp=00", {os_tick, tx_bit_tick, rx_sample_tick, cfg_err, rx_os_phase});
    end
    en = 1'b0;
    step(); step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if ({os_tick, tx_bit_tick, rx_sample_tick, cfg_err, rx_os_phase} !== 8'h00) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL rst_quiet got=%0d exp=0", bad); end
    en = 1'b1;
    step();
    for (int k = 1; k <= 8; k++) begin
      step();
      e = ((k % 4) == 0);
      checks++;
      if (os_tick !== e) begin errors++; $display("FAIL rst_resume k=%0d got=%b exp=%b", k, os_tick, e); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_m4();
    test_frac();
    test_m1();
    test_rx_sync();
    test_rx_sync_coincident();
    test_cfg_err();
    test_en_low();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
